// File: rtl/lcd_write_sequencer.sv
// Write sequencer for the Spartan-3E character LCD 4-bit bus: HD44780 power-on
// nibble init, then byte writes split into two enable-strobed nibbles.
module lcd_write_sequencer #(
  parameter int SETUP_CYC      = 2,
  parameter int PULSE_CYC      = 12,
  parameter int HOLD_CYC       = 1,
  parameter int NIB_GAP_CYC    = 50,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int LONG_WAIT_CYC  = 82000,
  parameter int POWERON_CYC    = 750000,
  parameter int INIT1_WAIT_CYC = 205000,
  parameter int INIT2_WAIT_CYC = 5000
) (
  input  logic       Clock,
  input  logic       iReset,
  input  logic       iWriteReq,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oWriteDone,
  output logic       oInitDone,
  output logic [3:0] oLCD_Data,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_Enabled
);

  typedef enum logic [3:0] {
    INIT_POWERON,
    INIT_NIB,
    INIT_WAIT,
    IDLE,
    NIB_SETUP,
    NIB_PULSE,
    NIB_HOLD,
    NIB_GAP,
    CMD_WAIT,
    DONE
  } state_t;

  // Terminal counts: the shared up-counter runs 0..N-1 so each state lasts N cycles.
  localparam logic [19:0] C_SETUP   = 20'(SETUP_CYC - 1);
  localparam logic [19:0] C_PULSE   = 20'(PULSE_CYC - 1);
  localparam logic [19:0] C_HOLD    = 20'(HOLD_CYC - 1);
  localparam logic [19:0] C_GAP     = 20'(NIB_GAP_CYC - 1);
  localparam logic [19:0] C_CMD     = 20'(CMD_WAIT_CYC - 1);
  localparam logic [19:0] C_LONG    = 20'(LONG_WAIT_CYC - 1);
  localparam logic [19:0] C_POWERON = 20'(POWERON_CYC - 1);
  localparam logic [19:0] C_INIT1   = 20'(INIT1_WAIT_CYC - 1);
  localparam logic [19:0] C_INIT2   = 20'(INIT2_WAIT_CYC - 1);

  state_t      state;
  logic [19:0] cnt;
  logic [19:0] dur_m1;
  logic [7:0]  byte_lat;
  logic        rs_lat;
  logic        upper;
  logic        init_phase;
  logic [1:0]  init_step;
  logic        last;
  logic        long_wait;
  logic        accept;

  assign oLCD_ReadWrite = 1'b0;
  // Clear display and return home need the long execution time.
  assign long_wait = !rs_lat && (byte_lat inside {8'h01, 8'h02, 8'h03});
  assign accept    = oReady && iWriteReq;
  assign last      = (cnt == dur_m1);

  always_comb begin
    dur_m1 = '0;
    case (state)
      INIT_POWERON: dur_m1 = C_POWERON;
      NIB_SETUP:    dur_m1 = C_SETUP;
      NIB_PULSE:    dur_m1 = C_PULSE;
      NIB_HOLD:     dur_m1 = C_HOLD;
      NIB_GAP:      dur_m1 = C_GAP;
      CMD_WAIT:     dur_m1 = long_wait ? C_LONG : C_CMD;
      INIT_WAIT: begin
        case (init_step)
          2'd0:    dur_m1 = C_INIT1;
          2'd1:    dur_m1 = C_INIT2;
          default: dur_m1 = C_CMD;
        endcase
      end
      default:      dur_m1 = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge iReset) begin
    if (!iReset) begin
      state               <= INIT_POWERON;
      cnt                 <= '0;
      byte_lat            <= '0;
      rs_lat              <= 1'b0;
      upper               <= 1'b0;
      init_phase          <= 1'b1;
      init_step           <= '0;
      oReady              <= 1'b0;
      oWriteDone          <= 1'b0;
      oInitDone           <= 1'b0;
      oLCD_Data           <= '0;
      oLCD_RegisterSelect <= 1'b0;
      oLCD_Enabled        <= 1'b0;
    end else begin
      oWriteDone <= 1'b0;
      if (accept) begin
        byte_lat            <= iData;
        rs_lat              <= iRS;
        oLCD_Data           <= iData[7:4];
        oLCD_RegisterSelect <= iRS;
        upper               <= 1'b1;
        oReady              <= 1'b0;
        cnt                 <= '0;
        state               <= NIB_SETUP;
      end else begin
        cnt <= cnt + 20'd1;
        case (state)
          INIT_POWERON: begin
            if (last) begin
              cnt   <= '0;
              state <= INIT_NIB;
            end
          end
          INIT_NIB: begin
            oLCD_Data           <= (init_step == 2'd3) ? 4'h2 : 4'h3;
            oLCD_RegisterSelect <= 1'b0;
            cnt                 <= '0;
            state               <= NIB_SETUP;
          end
          NIB_SETUP: begin
            if (last) begin
              cnt          <= '0;
              oLCD_Enabled <= 1'b1;
              state        <= NIB_PULSE;
            end
          end
          NIB_PULSE: begin
            if (last) begin
              cnt          <= '0;
              oLCD_Enabled <= 1'b0;
              state        <= NIB_HOLD;
            end
          end
          NIB_HOLD: begin
            if (last) begin
              cnt <= '0;
              if (init_phase)
                state <= INIT_WAIT;
              else if (upper)
                state <= NIB_GAP;
              else
                state <= CMD_WAIT;
            end
          end
          NIB_GAP: begin
            if (last) begin
              cnt       <= '0;
              oLCD_Data <= byte_lat[3:0];
              upper     <= 1'b0;
              state     <= NIB_SETUP;
            end
          end
          INIT_WAIT: begin
            if (last) begin
              cnt <= '0;
              if (init_step == 2'd3) begin
                init_phase <= 1'b0;
                oInitDone  <= 1'b1;
                oReady     <= 1'b1;
                state      <= IDLE;
              end else begin
                init_step <= init_step + 2'd1;
                state     <= INIT_NIB;
              end
            end
          end
          CMD_WAIT: begin
            if (last) begin
              cnt        <= '0;
              oReady     <= 1'b1;
              oWriteDone <= 1'b1;
              state      <= DONE;
            end
          end
          DONE: begin
            cnt   <= '0;
            state <= IDLE;
          end
          default: begin
            cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
